// File: rtl/bus_sel_pkg.sv
// Shared definitions for the bus-source select path: source index map,
// select encoding helpers and the arbitration mode type.
package bus_sel_pkg;

  // Source indices, in the same order as the bus multiplexer inputs.
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // Select value meaning "no source drives the bus".
  localparam int SEL_NONE = 0;

  typedef enum logic {
    ARB_PRIORITY    = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_e;

  // The bus mux reserves select 0 for "none", so source i is select i+1.
  function automatic int idx_to_sel(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational first-set-bit finder. The search begins at start_i and wraps
// from NUM_SRC-1 back to 0, so with start_i=0 it is a plain lowest-index
// priority encoder.
module rr_priority_pick #(
  parameter int NUM_SRC = 24,
  parameter int IDX_W   = 5
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int               p;
  logic [IDX_W-1:0] pos;

  // Walk the ring from the farthest position back to start_i so the last
  // match written is the one closest to start_i.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    p       = 0;
    pos     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      p = int'(start_i) + k;
      if (p >= NUM_SRC) p = p - NUM_SRC;
      pos = IDX_W'(p);
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Registered bus-source arbiter: turns per-source drive requests into an
// index+1 encoded mux select, with optional round-robin, grant hold and a
// conflict monitor (flag, sticky flag and saturating counter).
module bus_source_arbiter
  import bus_sel_pkg::*;
#(
  parameter int NUM_SRC     = 24,
  parameter int SEL_W       = 5,
  parameter int ROUND_ROBIN = 0,
  parameter int CNT_W       = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               hold,
  input  logic               clr_err,
  output logic [SEL_W-1:0]   sel_out,
  output logic               sel_valid,
  output logic               conflict,
  output logic               conflict_sticky,
  output logic [CNT_W-1:0]   conflict_count
);

  localparam int              IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam arb_mode_e       ARB_MODE = (ROUND_ROBIN != 0) ? ARB_ROUND_ROBIN : ARB_PRIORITY;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // The select must encode every source plus the "none" value.
  generate
    if ((2 ** SEL_W) < (NUM_SRC + 1)) begin : g_sel_w_check
      $error("bus_source_arbiter: SEL_W too small for NUM_SRC+1 select values");
    end
  endgenerate

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             conflict_q, conflict_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] startIdx;
  logic [IDX_W-1:0] pickIdx;
  logic             pickFound;
  logic             holdActive;
  logic             multiReq;

  // Hold only freezes an existing grant; with nothing granted it is ignored.
  assign holdActive = hold & valid_q;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multiReq = (req & (req - NUM_SRC'(1))) != '0;

  // Round-robin searches from the slot after the last winner; priority mode always from 0.
  always_comb begin
    startIdx = '0;
    if ((ARB_MODE == ARB_ROUND_ROBIN) && (ptr_q != LAST_IDX)) begin
      startIdx = ptr_q + 1'b1;
    end
  end

  rr_priority_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req),
    .start_i (startIdx),
    .found_o (pickFound),
    .idx_o   (pickIdx)
  );

  // Next grant: keep it under an active hold, otherwise take the pick or drop to none.
  always_comb begin
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (!holdActive) begin
      if (pickFound) begin
        sel_d   = SEL_W'(idx_to_sel(int'(pickIdx)));
        valid_d = 1'b1;
        if (ARB_MODE == ARB_ROUND_ROBIN) begin
          ptr_d = pickIdx;
        end
      end else begin
        sel_d   = SEL_W'(SEL_NONE);
        valid_d = 1'b0;
      end
    end
  end

  // Conflict bookkeeping: a clear beats a same-cycle conflict, the counter never wraps.
  always_comb begin
    conflict_d = multiReq;
    sticky_d   = sticky_q;
    count_d    = count_q;
    if (clr_err) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end else if (multiReq) begin
      sticky_d = 1'b1;
      if (count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State registers; the pointer resets to the last slot so the first search starts at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
      ptr_q      <= LAST_IDX;
    end else begin
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
    end
  end

  assign sel_out         = sel_q;
  assign sel_valid       = valid_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;
  assign conflict_count  = count_q;

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Parametrised, registered successor to the combinational bus-source select encoder.
- Takes N per-source drive-request lines and produces an index+1 encoded bus-mux select (0 = no source).
  - Priority or round-robin arbitration.
  - Grant hold for multi-cycle transfers.
  - Conflict detection with a saturating error counter.
- Sits between the control unit's "xOut" signals and the bus multiplexer select input.

Parameters:
- NUM_SRC, 24, number of request inputs; index 0 is r0, order as in the bus mux.
- SEL_W, 5, select width; elaboration error if 2**SEL_W < NUM_SRC+1.
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- CNT_W, 8, width of the conflict counter.

Ports:
- clock, input, 1, rising-edge system clock.
- reset_n, input, 1, asynchronous active-low reset.
- req, input, NUM_SRC, per-source drive request; bit i = source i.
- hold, input, 1, freeze the current grant while sel_valid=1.
- clr_err, input, 1, synchronous clear of conflict_count and conflict_sticky.
- sel_out, output, SEL_W, registered select: granted index+1; 0 = none.
- sel_valid, output, 1, registered; 1 when sel_out != 0.
- conflict, output, 1, registered; 1 if more than one req bit was set in the previous cycle.
- conflict_sticky, output, 1, set by any conflict; cleared only by reset or clr_err.
- conflict_count, output, CNT_W, saturating count of conflict cycles.

Behaviour:
- Reset (reset_n=0, async):
  - sel_out=0, sel_valid=0, conflict=0, conflict_sticky=0, conflict_count=0.
  - Round-robin pointer = NUM_SRC-1, so the first search starts at index 0.
- Latency: all outputs are registered; req sampled at edge k appears on the outputs after edge k. Exactly 1 cycle, no combinational path from input to output.
- Fixed priority (ROUND_ROBIN=0): grant = lowest set index i; sel_out = i+1. Every bit is checked, with no skipped or duplicated index.
- Round-robin (ROUND_ROBIN=1):
  - Search starts at (ptr+1) mod NUM_SRC and wraps to 0 after NUM_SRC-1.
  - The first set bit wins; ptr := granted index.
  - ptr is unchanged when no req is set or when hold is applied.
- Hold:
  - If hold=1 and sel_valid=1, sel_out and sel_valid keep their values regardless of req, including req=0.
  - If hold=1 and sel_valid=0, hold is ignored and normal arbitration occurs.
- No request: if req == 0 and hold is inactive, sel_out=0 and sel_valid=0 on the next edge.
- Conflict:
  - conflict := (popcount(req) > 1), evaluated every cycle, including under hold.
  - On conflict, conflict_count increments by 1 and saturates at 2**CNT_W-1. It never wraps.
  - conflict_sticky := 1.
- clr_err:
  - Next edge: conflict_count=0 and conflict_sticky=0.
  - clr_err takes precedence over a simultaneous conflict, so the count is 0, not 1, that cycle.
  - The conflict output itself still reflects the current req.
  - clr_err does not affect sel_out, sel_valid or ptr.
- Reset mid-hold: all state clears immediately; the grant is lost and no output glitch-holds.
- The X/undriven req case is not handled; inputs are assumed to be driven by the control unit.

Decomposition:
- Shared package bus_sel_pkg holds:
  - Source index constants: SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C.
  - SEL_NONE = 0.
  - A function idx_to_sel(i) = i+1.
- One sub-module, rr_priority_pick: combinational pick of the first set bit starting at a given index, with wrap. It is also used with start=0 for fixed priority.
- Counters and registers stay in the top module.

Test Plan:
- Priority, single source: req = 1<<21 (MDR) → next cycle sel_out=22 (5'b10110), sel_valid=1, conflict=0.
- Priority conflict: req has bits 8 and 12 set → sel_out=9, conflict=1, conflict_count=1, sticky=1. Hold that req for 300 cycles with CNT_W=8 → count saturates at 255.
- Round-robin: ROUND_ROBIN=1, req bits {0,3,23} held constant → sel_out sequence 1, 4, 24, 1, 4 …, conflict=1 every cycle.
- Hold: grant req bit 5 (sel_out=6), then hold=1 and req changes to bit 2 and then to 0 → sel_out stays 6 for all held cycles. Release hold with req=bit 2 → sel_out=3 one cycle later.
- Clear vs conflict: count=7, then clr_err=1 in the same cycle as a 2-bit req → count=0, sticky=0, conflict=1. The next conflict cycle gives count=1.
- Async reset mid-operation: drop reset_n between edges while sel_valid=1 and count=10 → all outputs 0 immediately. After release, round-robin restarts at index 0.
